ledger_writer: RTL
==================

LEDGER_WRITER -- requirements
Module: ledger_writer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 3, giving the player-index width (2^ADDR_W ledger words).
REQ-002 The block SHALL have port CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port start  input  1  one-cycle request to execute a transfer; sampled only in IDLE.
REQ-005 The block SHALL have ports src_idx and dst_idx  input  ADDR_W each  sender and receiver ledger indices.
REQ-006 The block SHALL have port amount  input  8  transfer value, unsigned.
REQ-007 The block SHALL have ports mem_addr  output  ADDR_W, mem_re  output  1, mem_we  output  1, mem_wdata  output  12, all driving the ledger memory.
REQ-008 The block SHALL have port mem_rdata  input  12  ledger word, valid the cycle after mem_re with mem_addr; [11:8] tag, [7:0] balance.
REQ-009 The block SHALL have ports busy  output  1, done  output  1 (one-cycle pulse) and status  output  2 (00 ok, 01 insufficient funds, 10 overflow, 11 self-transfer).

Function
REQ-010 The FSM SHALL have states IDLE, RD_SRC, RD_DST, CHECK, WR_SRC, WR_DST, DONE; each non-IDLE state lasts one cycle.
REQ-011 In IDLE with start=1, the block SHALL latch src_idx, dst_idx and amount and enter RD_SRC; busy SHALL be 1 in every non-IDLE state.
REQ-012 start while busy=1 SHALL be ignored; latched operands SHALL not change until IDLE.
REQ-013 If src_idx==dst_idx at start, the block SHALL go directly to DONE with status 11 and no memory access.
REQ-014 RD_SRC SHALL drive mem_addr=src, mem_re=1; RD_DST SHALL drive mem_addr=dst, mem_re=1 and capture mem_rdata as the source word.
REQ-015 CHECK SHALL capture mem_rdata as the destination word and evaluate, in priority order: src balance < amount -> status 01, go to DONE; dst balance + amount > 255 -> overflow rule (REQ-025/026); otherwise go to WR_SRC.
REQ-016 WR_SRC SHALL drive mem_we=1, mem_addr=src, mem_wdata = {src tag unchanged, src balance - amount}.
REQ-017 WR_DST SHALL drive mem_we=1, mem_addr=dst, mem_wdata = {dst tag unchanged, new dst balance}, then go to DONE.
REQ-018 DONE SHALL assert done=1 for exactly one cycle, hold status until the next accepted start, and return to IDLE.
REQ-019 Latency SHALL be: successful transfer done 6 cycles after the start edge; funds/overflow error 4 cycles; self-transfer 1 cycle.
REQ-020 amount=0 SHALL complete as a successful transfer with both words rewritten unchanged.
REQ-021 No write SHALL occur on any error path; the ledger SHALL never be partially updated except by reset during WR_DST.
REQ-022 mem_re and mem_we SHALL never both be 1; outside their states they SHALL be 0.

Reset
REQ-023 reset=1 SHALL immediately force IDLE, busy=0, done=0, status=00, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0, regardless of the clock.
REQ-024 Reset asserted mid-transfer SHALL abort it with no done pulse; a start in the first cycle after reset release SHALL be accepted.

Configuration
REQ-025 With LEDGER_SATURATE_EN defined, overflow in CHECK SHALL NOT be an error: the destination balance SHALL saturate at 255, the transfer SHALL proceed to WR_SRC, and status SHALL be 10 (debit of the full amount still applied).
REQ-026 Without LEDGER_SATURATE_EN, overflow SHALL go to DONE with status 10 and no writes.

Verification
REQ-027 src=1 bal 100, dst=2 bal 50, amount 30 -> writes addr1=...064→0x?46 (70), addr2=80, tags preserved, done at cycle 6, status 00.
REQ-028 src bal 20, amount 21 -> no mem_we, done at cycle 4, status 01; amount 20 -> src 0, status 00.
REQ-029 dst bal 250, amount 10, src bal 100 -> without macro: no writes, status 10; with macro: src 90, dst 255, status 10.
REQ-030 src_idx=dst_idx=3 -> done at cycle 1, status 11, mem_re and mem_we never asserted.
REQ-031 start pulsed again during RD_DST with different operands -> ignored, original transfer completes unchanged.
REQ-032 reset asserted during WR_SRC -> mem_we drops combinationally at reset, no done, busy=0; new start after release completes normally.

Source files
------------

// File: rtl/ledger_writer.sv
// ledger_writer: moves `amount` from one ledger word to another through a
// single-port synchronous-read memory, with funds, overflow and self-transfer
// checks. A transfer is read-src, read-dst, check, write-src, write-dst, done.
//
// Optional feature: define LEDGER_SATURATE_EN to make destination overflow
// saturate at 255 (transfer still completes, status 10) instead of aborting.
//
// Ports:
//   CLOCK_50            clock, rising edge
//   reset               asynchronous active-high reset
//   start               transfer request, sampled only when idle
//   src_idx, dst_idx    sender / receiver ledger indices
//   amount              unsigned transfer value
//   mem_addr/re/we/wdata ledger memory request (registered)
//   mem_rdata           ledger word, valid the cycle after mem_re; [11:8] tag, [7:0] balance
//   busy                high in every non-idle state
//   done                one-cycle completion pulse
//   status              00 ok, 01 insufficient funds, 10 overflow, 11 self-transfer
module ledger_writer #(
  parameter int unsigned ADDR_W = 3
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_idx,
  input  logic [ADDR_W-1:0] dst_idx,
  input  logic [7:0]        amount,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [11:0]       mem_wdata,
  input  logic [11:0]       mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status
);

  typedef enum logic [2:0] {
    StIdle,
    StRdSrc,
    StRdDst,
    StCheck,
    StWrSrc,
    StWrDst,
    StDone
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [7:0]        amt_q;
  logic [11:0]       src_word;
  logic [3:0]        dst_tag;
  logic [7:0]        dst_bal_new;

  // Destination balance plus amount, carry in bit 8 flags overflow.
  logic [8:0] dst_sum;
  assign dst_sum = {1'b0, mem_rdata[7:0]} + {1'b0, amt_q};

  // Outputs are registered: each branch sets the outputs belonging to the
  // state being entered, so they are valid for that whole state.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state       <= StIdle;
      src_q       <= '0;
      dst_q       <= '0;
      amt_q       <= '0;
      src_word    <= '0;
      dst_tag     <= '0;
      dst_bal_new <= '0;
      mem_addr    <= '0;
      mem_re      <= 1'b0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      status      <= 2'b00;
    end else begin
      mem_re <= 1'b0;
      mem_we <= 1'b0;
      done   <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            src_q  <= src_idx;
            dst_q  <= dst_idx;
            amt_q  <= amount;
            busy   <= 1'b1;
            status <= 2'b00;
            if (src_idx == dst_idx) begin
              state  <= StDone;
              status <= 2'b11;
              done   <= 1'b1;
            end else begin
              state    <= StRdSrc;
              mem_addr <= src_idx;
              mem_re   <= 1'b1;
            end
          end
        end
        StRdSrc: begin
          state    <= StRdDst;
          mem_addr <= dst_q;
          mem_re   <= 1'b1;
        end
        StRdDst: begin
          // Read data for the source request arrives now.
          src_word <= mem_rdata;
          state    <= StCheck;
        end
        StCheck: begin
          dst_tag <= mem_rdata[11:8];
          if (src_word[7:0] < amt_q) begin
            status <= 2'b01;
            state  <= StDone;
            done   <= 1'b1;
          end else if (dst_sum[8]) begin
            status <= 2'b10;
`ifdef LEDGER_SATURATE_EN
            dst_bal_new <= 8'hff;
            state       <= StWrSrc;
            mem_we      <= 1'b1;
            mem_addr    <= src_q;
            mem_wdata   <= {src_word[11:8], src_word[7:0] - amt_q};
`else
            state <= StDone;
            done  <= 1'b1;
`endif
          end else begin
            dst_bal_new <= dst_sum[7:0];
            state       <= StWrSrc;
            mem_we      <= 1'b1;
            mem_addr    <= src_q;
            mem_wdata   <= {src_word[11:8], src_word[7:0] - amt_q};
          end
        end
        StWrSrc: begin
          state     <= StWrDst;
          mem_we    <= 1'b1;
          mem_addr  <= dst_q;
          mem_wdata <= {dst_tag, dst_bal_new};
        end
        StWrDst: begin
          state <= StDone;
          done  <= 1'b1;
        end
        StDone: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
